// File: rtl/tx_pkg.sv
// Shared state encoding and default widths for the TX key shaper.
package tx_pkg;

  localparam int LBITS_DEF   = 16;
  localparam int RAMP_AW_DEF = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PA_WAIT   = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_HANG      = 3'd5
  } tx_state_e;

endpackage

// File: rtl/tx_env_scale.sv
// Registered level x envelope multiply, result >> LBITS; a signed level
// is truncated toward zero, an unsigned level is a plain floor.
module tx_env_scale #(
  parameter int LBITS        = 16,
  parameter bit SIGNED_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [LBITS-1:0] level,
  input  logic [LBITS-1:0] env,
  output logic [LBITS-1:0] scaled
);

  localparam int            PW  = 2*LBITS + 2;
  localparam logic [PW-1:0] RND = {{(LBITS+2){1'b0}}, {LBITS{1'b1}}};

  logic [PW-1:0]        lvl_x;
  logic [PW-1:0]        env_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] biased;
  logic                 unused_bits;

  always_comb begin
    lvl_x  = SIGNED_LEVEL ? {{(LBITS+2){level[LBITS-1]}}, level} : {{(LBITS+2){1'b0}}, level};
    env_x  = {{(LBITS+2){1'b0}}, env};
    prod   = $signed(lvl_x) * $signed(env_x);
    // negative products get a bias so dropping the low bits rounds toward zero
    biased = prod[PW-1] ? prod + $signed(RND) : prod;
  end

  assign unused_bits = ^{biased[PW-1:2*LBITS], biased[LBITS-1:0]};

  always_ff @(posedge clock) begin
    if (reset) scaled <= '0;
    else       scaled <= biased[2*LBITS-1:LBITS];
  end

endmodule

// File: rtl/tx_key_shaper.sv
// Keying sequencer with PA lead-in, ROM-profile ramp and hang time.
// Optional TX_IQ_RAMP_EN: phone IQ is scaled by the ramp instead of hard-gated.
//
// state        | meaning
// ST_IDLE      | PA off, waiting for cw_key|ptt
// ST_PA_WAIT   | PA on, counting lead-in steps before RF
// ST_RAMP_UP   | ramp index rising one per step
// ST_HOLD      | ramp index at maximum
// ST_RAMP_DOWN | ramp index falling one per step
// ST_HANG      | RF off, PA held for HANG steps
module tx_key_shaper
  import tx_pkg::*;
#(
  parameter int LBITS   = LBITS_DEF,
  parameter int RAMP_AW = RAMP_AW_DEF,
  parameter int PA_DLY  = 64,
  parameter int HANG    = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    step,
  input  logic                    cw_key,
  input  logic                    ptt,
  input  logic                    iq_valid,
  input  logic signed [LBITS-1:0] iq_real,
  input  logic signed [LBITS-1:0] iq_imag,
  input  logic [LBITS-1:0]        cw_max,
  output logic [RAMP_AW-1:0]      rom_addr,
  input  logic [LBITS-1:0]        rom_data,
  output logic signed [LBITS-1:0] out_real,
  output logic signed [LBITS-1:0] out_imag,
  output logic                    out_valid,
  output logic                    pa_enable,
  output logic                    tx_active
);

  localparam int                 CNT_MAX = (PA_DLY > HANG) ? PA_DLY : HANG;
  localparam int                 CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   PA_TC   = CNT_W'(PA_DLY - 1);
  localparam logic [CNT_W-1:0]   HANG_TC = CNT_W'(HANG - 1);
  localparam logic [RAMP_AW-1:0] IDX_MAX = '1;

  tx_state_e          state, state_nx;
  logic [RAMP_AW-1:0] idx, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               mode_cw, mode_nx;
  logic               req, ramping;
  logic [1:0]         ramp_d;

  always_comb begin
    req      = cw_key | ptt;
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    mode_nx  = mode_cw;
    // request-driven moves first; a step in the same clock acts in the new state
    unique case (state)
      ST_IDLE:             if (req) begin state_nx = ST_PA_WAIT; cnt_nx = '0; mode_nx = cw_key; end
      ST_RAMP_UP, ST_HOLD: if (!req) state_nx = ST_RAMP_DOWN;
      ST_RAMP_DOWN:        if (req) state_nx = ST_RAMP_UP;
      ST_HANG:             if (req) begin state_nx = ST_RAMP_UP; idx_nx = '0; end
      default:             ;
    endcase
    if (step) begin
      case (state_nx)
        ST_PA_WAIT: begin
          if (cnt_nx == PA_TC) begin
            cnt_nx   = '0;
            state_nx = req ? ST_RAMP_UP : ST_HANG;
          end else begin
            cnt_nx = cnt_nx + CNT_W'(1);
          end
        end
        ST_RAMP_UP: begin
          if (idx_nx != IDX_MAX) idx_nx = idx_nx + RAMP_AW'(1);
          if (idx_nx == IDX_MAX) state_nx = ST_HOLD;
        end
        ST_RAMP_DOWN: begin
          if (idx_nx != '0) idx_nx = idx_nx - RAMP_AW'(1);
          if (idx_nx == '0) begin state_nx = ST_HANG; cnt_nx = '0; end
        end
        ST_HANG: begin
          if (cnt_nx == HANG_TC) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            mode_nx  = 1'b0;
          end else begin
            cnt_nx = cnt_nx + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      mode_cw <= 1'b0;
      ramp_d  <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      mode_cw <= mode_nx;
      ramp_d  <= {ramp_d[0], ramping};
    end
  end

  assign ramping   = (state == ST_RAMP_UP) || (state == ST_HOLD) || (state == ST_RAMP_DOWN);
  assign tx_active = ramping | (|ramp_d);
  assign pa_enable = (state != ST_IDLE);
  assign rom_addr  = idx;

  logic [LBITS-1:0] cw_scaled;

  tx_env_scale #(.LBITS(LBITS), .SIGNED_LEVEL(1'b0)) u_cw_scale (
    .clock  (clock),
    .reset  (reset),
    .level  (cw_max),
    .env    (rom_data),
    .scaled (cw_scaled)
  );

  // phone path: gate on ramp state at entry, two register stages to match the ROM path
  logic             ph_v1, ph_v2;
  logic [LBITS-1:0] ph_re1, ph_im1, ph_re2, ph_im2;

  always_ff @(posedge clock) begin
    if (reset) begin
      ph_v1  <= 1'b0;
      ph_re1 <= '0;
      ph_im1 <= '0;
      ph_v2  <= 1'b0;
    end else begin
      ph_v1  <= ramping & iq_valid;
      ph_re1 <= ramping ? iq_real : '0;
      ph_im1 <= ramping ? iq_imag : '0;
      ph_v2  <= ph_v1;
    end
  end

`ifdef TX_IQ_RAMP_EN
  tx_env_scale #(.LBITS(LBITS), .SIGNED_LEVEL(1'b1)) u_re_scale (
    .clock  (clock),
    .reset  (reset),
    .level  (ph_re1),
    .env    (rom_data),
    .scaled (ph_re2)
  );

  tx_env_scale #(.LBITS(LBITS), .SIGNED_LEVEL(1'b1)) u_im_scale (
    .clock  (clock),
    .reset  (reset),
    .level  (ph_im1),
    .env    (rom_data),
    .scaled (ph_im2)
  );
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      ph_re2 <= '0;
      ph_im2 <= '0;
    end else begin
      ph_re2 <= ph_re1;
      ph_im2 <= ph_im1;
    end
  end
`endif

  always_comb begin
    if (mode_cw) begin
      out_real  = tx_active ? cw_scaled : '0;
      out_imag  = '0;
      out_valid = tx_active;
    end else begin
      out_real  = ph_re2;
      out_imag  = ph_im2;
      out_valid = ph_v2;
    end
  end

endmodule

// File: tb/tb_tx_key_shaper.sv
// Bench for tx_key_shaper: directed keying scenarios plus randomized traffic
// compared every clock against a phase-level model of the sequencer.
module tb_tx_key_shaper;

  localparam int PA_N   = 4;
  localparam int HANG_N = 6;
  localparam int MAXI   = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0, cw_key = 1'b0, ptt = 1'b0, iq_valid = 1'b0;
  logic [15:0] iq_real = '0, iq_imag = '0, cw_max = 16'hFFFF;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] out_real, out_imag;
  logic        out_valid, pa_enable, tx_active;

  logic [15:0] rom [0:7];

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;
  bit step_rand = 1'b0;
  int steps_seen = 0;

  tx_key_shaper #(.LBITS(16), .RAMP_AW(3), .PA_DLY(PA_N), .HANG(HANG_N)) dut (
    .clock     (clk),
    .reset     (rst),
    .step      (step),
    .cw_key    (cw_key),
    .ptt       (ptt),
    .iq_valid  (iq_valid),
    .iq_real   (iq_real),
    .iq_imag   (iq_imag),
    .cw_max    (cw_max),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_valid (out_valid),
    .pa_enable (pa_enable),
    .tx_active (tx_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      step = step_rand ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
    end
  end

  function automatic int scale(input logic [15:0] x, input logic [15:0] r);
    longint p;
    p = longint'($signed(x)) * longint'(r);
    return int'(p / 65536);
  endfunction

  // model: phase 0 off, 1 PA lead-in, 2 RF on (ramp/hold), 3 hang
  int          m_ph, m_cnt, m_lvl, c_lvl, h_lvl, cwv, ph_re, ph_im;
  bit          m_cw, c_on, h_on, n_on, p_v, req;
  logic [15:0] p_re, p_im;
  logic [15:0] e_re, e_im;
  int          e_addr;
  bit          e_v, e_pa, e_tx;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_lvl = 0; m_cw = 1'b0;
      c_on = 1'b0; h_on = 1'b0; c_lvl = 0; h_lvl = 0;
      p_re = '0; p_im = '0; p_v = 1'b0;
      e_re = '0; e_im = '0; e_addr = 0; e_v = 1'b0; e_pa = 1'b0; e_tx = 1'b0;
    end else begin
      if (step) steps_seen++;
      req = cw_key | ptt;
`ifdef TX_IQ_RAMP_EN
      ph_re = scale(p_re, rom[h_lvl]);
      ph_im = scale(p_im, rom[h_lvl]);
`else
      ph_re = int'($signed(p_re));
      ph_im = int'($signed(p_im));
`endif
      if (!h_on) begin ph_re = 0; ph_im = 0; end
      cwv = int'((longint'(cw_max) * longint'(rom[h_lvl])) >> 16);
      if (m_ph == 0 && req) begin m_ph = 1; m_cnt = PA_N; m_cw = cw_key; end
      else if (m_ph == 3 && req) begin m_ph = 2; m_lvl = 0; end
      if (step) begin
        if (m_ph == 1) begin
          m_cnt--;
          if (m_cnt == 0) begin
            if (req) begin m_ph = 2; m_lvl = 0; end
            else begin m_ph = 3; m_cnt = HANG_N; end
          end
        end else if (m_ph == 2) begin
          if (req) m_lvl = (m_lvl < MAXI) ? m_lvl + 1 : MAXI;
          else if (m_lvl <= 1) begin m_lvl = 0; m_ph = 3; m_cnt = HANG_N; end
          else m_lvl--;
        end else if (m_ph == 3) begin
          m_cnt--;
          if (m_cnt == 0) begin m_ph = 0; m_cw = 1'b0; end
        end
      end
      n_on   = (m_ph == 2);
      e_tx   = n_on | c_on | h_on;
      e_pa   = (m_ph != 0);
      e_addr = m_lvl;
      if (m_cw) begin
        e_re = e_tx ? 16'(cwv) : '0;
        e_im = '0;
        e_v  = e_tx;
      end else begin
        e_re = 16'(ph_re);
        e_im = 16'(ph_im);
        e_v  = h_on & p_v;
      end
      h_on = c_on; h_lvl = c_lvl; c_on = n_on; c_lvl = m_lvl;
      p_re = iq_real; p_im = iq_imag; p_v = iq_valid;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rom_addr", int'(rom_addr), e_addr);
      chk("pa_enable", int'(pa_enable), int'(e_pa));
      chk("tx_active", int'(tx_active), int'(e_tx));
      chk("out_valid", int'(out_valid), int'(e_v));
      chk("out_real", int'(out_real), int'(e_re));
      chk("out_imag", int'(out_imag), int'(e_im));
    end
  end

  task automatic wait_addr(input int a, input string nm);
    for (int k = 0; k < 400 && int'(rom_addr) != a; k++) @(negedge clk);
    chk(nm, int'(rom_addr), a);
  endtask

  task automatic wait_pa(input bit v, input string nm);
    for (int k = 0; k < 400 && pa_enable != v; k++) @(negedge clk);
    chk(nm, int'(pa_enable), int'(v));
  endtask

  int q[$];
  int last, s0;
  bit flag;

  initial begin
    for (int k = 0; k < 8; k++) rom[k] = 16'(k * 8192);
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_pa", int'(pa_enable), 0);
    chk("rst_tx", int'(tx_active), 0);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_out", int'(out_real), 0);
    chk("rst_valid", int'(out_valid), 0);
    rst = 1'b0;

    // CW key-down ramp to hold
    @(negedge clk); cw_key = 1'b1;
    @(negedge clk); chk("pa_rise", int'(pa_enable), 1);
    q.delete(); last = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (int'(out_real) != last) begin q.push_back(int'(out_real)); last = int'(out_real); end
      if (rom_addr == 3'd7 && out_real == 16'd57343) break;
    end
    chk("ramp_len", q.size(), 7);
    for (int k = 0; k < 7; k++) chk("ramp_val", (k < q.size()) ? q[k] : -1, (k + 1) * 8192 - 1);
    repeat (12) @(negedge clk);
    chk("hold_addr", int'(rom_addr), 7);
    chk("hold_out", int'(out_real), 57343);
    chk("hold_imag", int'(out_imag), 0);

    // reset in HOLD, then the held key restarts a lead-in
    rst = 1'b1;
    @(negedge clk);
    chk("hrst_pa", int'(pa_enable), 0);
    chk("hrst_addr", int'(rom_addr), 0);
    chk("hrst_tx", int'(tx_active), 0);
    chk("hrst_out", int'(out_real), 0);
    chk("hrst_valid", int'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk); chk("restart_pa", int'(pa_enable), 1);

    // release at index 5 mid ramp-up
    wait_addr(5, "up_to5");
    cw_key = 1'b0;
    q.delete(); last = 5;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (int'(rom_addr) != last) begin q.push_back(int'(rom_addr)); last = int'(rom_addr); end
      if (rom_addr == 3'd0) break;
    end
    chk("down_len", q.size(), 5);
    for (int k = 0; k < 5; k++) chk("down_val", (k < q.size()) ? q[k] : -1, 4 - k);
    s0 = steps_seen;
    wait_pa(1'b0, "hang_end");
    chk("hang_steps", steps_seen - s0, HANG_N);

    // re-key during hang
    @(negedge clk); cw_key = 1'b1;
    wait_addr(2, "rekey_up");
    cw_key = 1'b0;
    wait_addr(0, "rekey_down");
    s0 = steps_seen;
    for (int k = 0; k < 100 && steps_seen < s0 + 3; k++) @(negedge clk);
    chk("hang_wait", steps_seen - s0, 3);
    cw_key = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!pa_enable) flag = 1'b1;
      if (rom_addr != 3'd0) break;
    end
    chk("pa_kept", int'(flag), 0);
    chk("reup_addr", int'(rom_addr), 1);
    cw_key = 1'b0;
    wait_pa(1'b0, "rekey_off");

    // phone mode
    @(negedge clk);
    ptt = 1'b1; iq_valid = 1'b1; iq_real = 16'd1000; iq_imag = 16'hFC18;
    flag = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (tx_active) break;
      if (out_real != 16'd0 || out_valid) flag = 1'b1;
    end
    chk("ph_pre", int'(flag), 0);
    chk("ph_tx", int'(tx_active), 1);
    @(negedge clk); chk("ph_lat1", int'(out_real), 0);
    @(negedge clk);
`ifdef TX_IQ_RAMP_EN
    chk("ph_idx0", int'(out_real), 0);
    wait_addr(4, "ph_up4");
    repeat (2) @(negedge clk);
    chk("ph_re4", int'($signed(out_real)), 500);
    chk("ph_im4", int'($signed(out_imag)), -500);
`else
    chk("ph_re", int'($signed(out_real)), 1000);
    chk("ph_im", int'($signed(out_imag)), -1000);
`endif
    chk("ph_valid", int'(out_valid), 1);
    ptt = 1'b0;
    wait_pa(1'b0, "ph_off");

    // randomized traffic with random step timing and ROM profiles
    step_rand = 1'b1;
    for (int seg = 0; seg < 5; seg++) begin
      rst = 1'b1;
      for (int k = 0; k < 8; k++) rom[k] = 16'($urandom_range(0, 65535));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 2500; n++) begin
        @(negedge clk);
        if ($urandom_range(0, 19) == 0) cw_key = ~cw_key;
        if ($urandom_range(0, 24) == 0) ptt = ~ptt;
        iq_real  = 16'($urandom);
        iq_imag  = 16'($urandom);
        iq_valid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 49) == 0) cw_max = 16'($urandom);
        rst = ($urandom_range(0, 799) == 0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
